// File: rtl/aq_ifu_pkg.sv
// Shared IFU instruction-buffer types: buffer entry layout, fetch-group size
// and the outstanding-fetch state encoding.
package aq_ifu_pkg;

    localparam int INST_WIDTH    = 32;
    localparam int IBUF_PC_WIDTH = 39;
    localparam int FETCH_INSTS   = 2;

    typedef struct packed {
        logic [INST_WIDTH-1:0]    inst;
        logic [IBUF_PC_WIDTH-1:0] pc;
        logic                     expt;
    } ibuf_entry_t;

    typedef enum logic [1:0] {
        OUTS_NONE = 2'd0,
        OUTS_ONE  = 2'd1,
        OUTS_TWO  = 2'd2
    } outs_e;

    // Number of instructions a returning fetch group actually deposits.
    function automatic logic [1:0] insts_written(input logic wr_vld,
                                                 input logic inst0_vld,
                                                 input logic inst1_vld);
        return wr_vld ? ({1'b0, inst0_vld} + {1'b0, inst1_vld}) : 2'd0;
    endfunction

endpackage

// File: rtl/aq_ifu_ibuf_queue_if.sv
// Bus bundle between IPack (write side), the instruction buffer and IDU (read side).
interface aq_ifu_ibuf_queue_if #(
    parameter int PC_WIDTH = 39
);
    import aq_ifu_pkg::*;

    // Write side has no ready: space was reserved when the fetch was issued.
    // Read side: an entry is transferred on a cycle where inst_vld and the
    // consumer's pop enable are both high; head data holds while not popped.
    logic                  ipack_ibuf_wr_vld;
    logic                  ipack_ibuf_inst0_vld;
    logic [INST_WIDTH-1:0] ipack_ibuf_inst0;
    logic [PC_WIDTH-1:0]   ipack_ibuf_inst0_pc;
    logic                  ipack_ibuf_inst0_expt;
    logic                  ipack_ibuf_inst1_vld;
    logic [INST_WIDTH-1:0] ipack_ibuf_inst1;
    logic [PC_WIDTH-1:0]   ipack_ibuf_inst1_pc;
    logic                  ipack_ibuf_inst1_expt;

    logic                  ibuf_idu_inst_vld;
    logic [INST_WIDTH-1:0] ibuf_idu_inst;
    logic [PC_WIDTH-1:0]   ibuf_idu_pc;
    logic                  ibuf_idu_expt;

    modport master (
        output ipack_ibuf_wr_vld, ipack_ibuf_inst0_vld, ipack_ibuf_inst0,
               ipack_ibuf_inst0_pc, ipack_ibuf_inst0_expt, ipack_ibuf_inst1_vld,
               ipack_ibuf_inst1, ipack_ibuf_inst1_pc, ipack_ibuf_inst1_expt,
        input  ibuf_idu_inst_vld, ibuf_idu_inst, ibuf_idu_pc, ibuf_idu_expt
    );

    modport slave (
        input  ipack_ibuf_wr_vld, ipack_ibuf_inst0_vld, ipack_ibuf_inst0,
               ipack_ibuf_inst0_pc, ipack_ibuf_inst0_expt, ipack_ibuf_inst1_vld,
               ipack_ibuf_inst1, ipack_ibuf_inst1_pc, ipack_ibuf_inst1_expt,
        output ibuf_idu_inst_vld, ibuf_idu_inst, ibuf_idu_pc, ibuf_idu_expt
    );

endinterface

// File: rtl/aq_ifu_ibuf_credit.sv
// Fetch credit: tracks outstanding fetch groups and only offers a new fetch
// when the buffer can absorb it on top of every group already in flight.
module aq_ifu_ibuf_credit
    import aq_ifu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_b_i,
    input  logic                   flush_i,
    input  logic                   req_ack_i,
    input  logic                   wr_vld_i,
    input  logic [$clog2(DEPTH):0] count_i,
    output logic                   fetch_o,
    output outs_e                  outs_o
);

    localparam int UW = $clog2(DEPTH) + 3;

    outs_e         outs_q, outs_d;
    logic          fetch_q, fetch_d;
    logic          flush_q;
    logic          inc, dec;
    logic [UW-1:0] used;

    // The cycle after a flush never offers a fetch, so the redirect PC is the
    // first request seen by the ICache.
    assign fetch_o = fetch_q && !flush_q;
    assign inc     = fetch_o && req_ack_i;
    assign dec     = wr_vld_i;
    assign outs_o  = outs_q;

    always_ff @(posedge clk_i) begin
        if (!rst_b_i) begin
            outs_q  <= OUTS_NONE;
            fetch_q <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            outs_q  <= outs_d;
            fetch_q <= fetch_d;
            flush_q <= flush_i;
        end
    end

    always_comb begin
        outs_d = outs_q;
        if (flush_i) begin
            outs_d = OUTS_NONE;
        end else if (inc && !dec) begin
            case (outs_q)
                OUTS_NONE: outs_d = OUTS_ONE;
                default:   outs_d = OUTS_TWO;
            endcase
        end else if (dec && !inc) begin
            case (outs_q)
                OUTS_TWO: outs_d = OUTS_ONE;
                default:  outs_d = OUTS_NONE;
            endcase
        end
    end

    always_comb begin
        used    = UW'(count_i) + UW'(FETCH_INSTS) * UW'(outs_q);
        fetch_d = ((used + UW'(FETCH_INSTS)) <= UW'(DEPTH)) && (outs_q != OUTS_TWO);
    end

    always @(posedge clk_i) begin
        if (rst_b_i && inc && !flush_i) begin
            assert (outs_q != OUTS_TWO);
        end
    end

endmodule

// File: rtl/aq_ifu_ibuf_queue.sv
// IFU instruction buffer: circular entry array filled up to two per cycle by
// IPack and drained one per cycle towards IDU, with a fetch credit output.
module aq_ifu_ibuf_queue
    import aq_ifu_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int PC_WIDTH = IBUF_PC_WIDTH
) (
    input  logic               forever_cpuclk,
    input  logic               cpurst_b,
    input  logic               ctrl_ibuf_pop_en,
    input  logic               ctrl_ibuf_flush,
    input  logic               icache_ibuf_req_ack,
    output logic               ibuf_ctrl_inst_fetch,
    output logic               ibuf_top_empty,
    aq_ifu_ibuf_queue_if.slave ibuf_if
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int CW1 = CW + 1;

    ibuf_entry_t         mem_q [DEPTH];
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       wr_ptr_p1;
    logic [CW-1:0]       count_q, count_d;
    logic [1:0]          n_wr;
    logic                head_vld;
    logic                pop;
    logic                wr0_en, wr1_en;
    ibuf_entry_t         ent0, ent1, head;
    logic [PC_WIDTH-1:0] head_pc;
    outs_e               outs;

    assign n_wr = insts_written(ibuf_if.ipack_ibuf_wr_vld,
                                ibuf_if.ipack_ibuf_inst0_vld,
                                ibuf_if.ipack_ibuf_inst1_vld);

    assign head_vld  = (count_q != '0);
    assign pop       = head_vld && ctrl_ibuf_pop_en;
    assign wr_ptr_p1 = wr_ptr_q + PW'(1);
    assign wr0_en    = cpurst_b && !ctrl_ibuf_flush &&
                       ibuf_if.ipack_ibuf_wr_vld && ibuf_if.ipack_ibuf_inst0_vld;
    assign wr1_en    = cpurst_b && !ctrl_ibuf_flush &&
                       ibuf_if.ipack_ibuf_wr_vld && ibuf_if.ipack_ibuf_inst1_vld;

    assign ent0 = '{inst: ibuf_if.ipack_ibuf_inst0,
                    pc:   ibuf_if.ipack_ibuf_inst0_pc,
                    expt: ibuf_if.ipack_ibuf_inst0_expt};
    assign ent1 = '{inst: ibuf_if.ipack_ibuf_inst1,
                    pc:   ibuf_if.ipack_ibuf_inst1_pc,
                    expt: ibuf_if.ipack_ibuf_inst1_expt};

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (ctrl_ibuf_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PW'(n_wr);
            rd_ptr_d = rd_ptr_q + PW'(pop);
            count_d  = count_q + CW'(n_wr) - CW'(pop);
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry payload carries no reset; validity is tracked by count alone.
    always_ff @(posedge forever_cpuclk) begin
        if (wr0_en) begin
            mem_q[wr_ptr_q] <= ent0;
        end
        if (wr1_en) begin
            mem_q[wr_ptr_p1] <= ent1;
        end
    end

    assign head    = mem_q[rd_ptr_q];
    assign head_pc = head.pc;

    assign ibuf_if.ibuf_idu_inst_vld = head_vld;
    assign ibuf_if.ibuf_idu_inst     = head_vld ? head.inst : '0;
    assign ibuf_if.ibuf_idu_pc       = head_vld ? head_pc : '0;
    assign ibuf_if.ibuf_idu_expt     = head_vld && head.expt;

    aq_ifu_ibuf_credit #(
        .DEPTH (DEPTH)
    ) u_credit (
        .clk_i     (forever_cpuclk),
        .rst_b_i   (cpurst_b),
        .flush_i   (ctrl_ibuf_flush),
        .req_ack_i (icache_ibuf_req_ack),
        .wr_vld_i  (ibuf_if.ipack_ibuf_wr_vld),
        .count_i   (count_q),
        .fetch_o   (ibuf_ctrl_inst_fetch),
        .outs_o    (outs)
    );

    assign ibuf_top_empty = !head_vld && (outs == OUTS_NONE);

    always @(posedge forever_cpuclk) begin
        if (cpurst_b && ibuf_if.ipack_ibuf_wr_vld) begin
            assert (ibuf_if.ipack_ibuf_inst0_vld || !ibuf_if.ipack_ibuf_inst1_vld);
            assert (ctrl_ibuf_flush ||
                    ((CW1'(count_q) + CW1'(n_wr)) <= CW1'(DEPTH)));
        end
    end

endmodule

// File: tb/tb_aq_ifu_ibuf_queue.sv
// Bench for the IFU instruction buffer: directed scenarios with literal
// expectations, then randomized traffic against a queue-based reference model.
module tb_aq_ifu_ibuf_queue;

    localparam int DEPTH = 8;
    localparam int PCW   = 39;
    localparam int EW    = 32 + PCW + 1;

    logic clk    = 1'b0;
    logic rst_b  = 1'b0;
    logic pop_en = 1'b0;
    logic flush  = 1'b0;
    logic ack    = 1'b0;
    logic fetch;
    logic top_empty;

    aq_ifu_ibuf_queue_if #(.PC_WIDTH(PCW)) bus ();

    aq_ifu_ibuf_queue #(
        .DEPTH    (DEPTH),
        .PC_WIDTH (PCW)
    ) dut (
        .forever_cpuclk       (clk),
        .cpurst_b             (rst_b),
        .ctrl_ibuf_pop_en     (pop_en),
        .ctrl_ibuf_flush      (flush),
        .icache_ibuf_req_ack  (ack),
        .ibuf_ctrl_inst_fetch (fetch),
        .ibuf_top_empty       (top_empty),
        .ibuf_if              (bus)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO contents, outstanding fetch groups, expected credit.
    logic [EW-1:0] exp_q[$];
    int            mout   = 0;
    logic          mfetch = 1'b0;
    int            total  = 0;
    int            bad    = 0;
    bit            chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit can_ack();
        return mfetch && (mout < 2) && (exp_q.size() + 2 * mout + 2 <= DEPTH);
    endfunction

    task automatic idle_wr();
        bus.ipack_ibuf_wr_vld     = 1'b0;
        bus.ipack_ibuf_inst0_vld  = 1'b0;
        bus.ipack_ibuf_inst0      = '0;
        bus.ipack_ibuf_inst0_pc   = '0;
        bus.ipack_ibuf_inst0_expt = 1'b0;
        bus.ipack_ibuf_inst1_vld  = 1'b0;
        bus.ipack_ibuf_inst1      = '0;
        bus.ipack_ibuf_inst1_pc   = '0;
        bus.ipack_ibuf_inst1_expt = 1'b0;
    endtask

    task automatic drive_wr(input int n, input logic [PCW-1:0] pc0, input logic [PCW-1:0] pc1,
                            input logic e0, input logic e1);
        bus.ipack_ibuf_wr_vld     = 1'b1;
        bus.ipack_ibuf_inst0_vld  = (n >= 1);
        bus.ipack_ibuf_inst0      = $urandom;
        bus.ipack_ibuf_inst0_pc   = pc0;
        bus.ipack_ibuf_inst0_expt = e0;
        bus.ipack_ibuf_inst1_vld  = (n == 2);
        bus.ipack_ibuf_inst1      = $urandom;
        bus.ipack_ibuf_inst1_pc   = pc1;
        bus.ipack_ibuf_inst1_expt = e1;
    endtask

    function automatic logic [PCW-1:0] rand_pc();
        return {$urandom_range(0, 127), $urandom} & {PCW{1'b1}};
    endfunction

    // Advance one clock; the model consumes the inputs seen at that edge.
    task automatic cycle();
        bit room;
        @(posedge clk);
        if (!rst_b) begin
            exp_q.delete();
            mout   = 0;
            mfetch = 1'b0;
        end else begin
            room = ((DEPTH - exp_q.size() - 2 * mout) >= 2) && (mout < 2);
            if (flush) begin
                exp_q.delete();
                mout   = 0;
                mfetch = 1'b0;
            end else begin
                if (pop_en && exp_q.size() > 0) void'(exp_q.pop_front());
                if (bus.ipack_ibuf_wr_vld) begin
                    if (bus.ipack_ibuf_inst0_vld)
                        exp_q.push_back({bus.ipack_ibuf_inst0, bus.ipack_ibuf_inst0_pc,
                                         bus.ipack_ibuf_inst0_expt});
                    if (bus.ipack_ibuf_inst1_vld)
                        exp_q.push_back({bus.ipack_ibuf_inst1, bus.ipack_ibuf_inst1_pc,
                                         bus.ipack_ibuf_inst1_expt});
                end
                mout = mout + ((mfetch && ack) ? 1 : 0) - (bus.ipack_ibuf_wr_vld ? 1 : 0);
                if (mout < 0) mout = 0;
                if (mout > 2) mout = 2;
                mfetch = room;
            end
        end
        #1;
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        logic [EW-1:0] h;
        if (chk_en) begin
            h = (exp_q.size() != 0) ? exp_q[0] : '0;
            chk("inst_vld", bus.ibuf_idu_inst_vld, exp_q.size() != 0);
            chk("inst", bus.ibuf_idu_inst, h[EW-1 -: 32]);
            chk("pc", bus.ibuf_idu_pc, h[PCW:1]);
            chk("expt", bus.ibuf_idu_expt, h[0]);
            chk("inst_fetch", fetch, mfetch);
            chk("top_empty", top_empty, (exp_q.size() == 0) && (mout == 0));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int guard;
        idle_wr();
        rst_b = 1'b0;
        repeat (3) cycle();
        chk_en = 1'b1;
        chk("rst_fetch", fetch, 0);
        chk("rst_vld", bus.ibuf_idu_inst_vld, 0);
        chk("rst_empty", top_empty, 1);

        rst_b = 1'b1;
        cycle();
        chk("first_fetch", fetch, 1);
        chk("first_empty", top_empty, 1);

        ack = 1'b1;
        cycle();
        ack = 1'b0;
        chk("ack_not_empty", top_empty, 0);

        drive_wr(2, 39'h1000, 39'h1004, 1'b0, 1'b1);
        pop_en = 1'b1;
        cycle();
        idle_wr();
        chk("head0_vld", bus.ibuf_idu_inst_vld, 1);
        chk("head0_pc", bus.ibuf_idu_pc, 39'h1000);
        chk("head0_expt", bus.ibuf_idu_expt, 0);
        cycle();
        chk("head1_pc", bus.ibuf_idu_pc, 39'h1004);
        chk("head1_expt", bus.ibuf_idu_expt, 1);
        cycle();
        chk("drained_vld", bus.ibuf_idu_inst_vld, 0);
        chk("drained_empty", top_empty, 1);

        // Fill to capacity with no pops.
        pop_en = 1'b0;
        guard  = 0;
        while ((exp_q.size() < DEPTH || mout > 0) && guard < 200) begin
            ack = can_ack();
            if (mout > 0) drive_wr(2, rand_pc(), rand_pc(), 1'b0, 1'b0);
            else idle_wr();
            cycle();
            guard++;
        end
        ack = 1'b0;
        idle_wr();
        chk("fill_bound", guard < 200, 1);
        chk("full_fetch", fetch, 0);
        chk("full_vld", bus.ibuf_idu_inst_vld, 1);

        pop_en = 1'b1;
        cycle();
        cycle();
        pop_en = 1'b0;
        cycle();
        chk("resume_fetch", fetch, 1);

        // Flush with an outstanding fetch and a same-cycle write.
        ack = 1'b1;
        cycle();
        ack = 1'b0;
        flush = 1'b1;
        pop_en = 1'b1;
        drive_wr(2, 39'h2000, 39'h2004, 1'b0, 1'b0);
        cycle();
        flush = 1'b0;
        pop_en = 1'b0;
        idle_wr();
        chk("flush_vld", bus.ibuf_idu_inst_vld, 0);
        chk("flush_empty", top_empty, 1);
        chk("flush_fetch", fetch, 0);
        cycle();
        chk("post_flush_fetch", fetch, 1);

        // Randomized traffic, with one reset in the middle.
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) begin
                ack = 1'b0;
                flush = 1'b0;
                pop_en = 1'b0;
                idle_wr();
                rst_b = 1'b0;
                cycle();
                cycle();
                rst_b = 1'b1;
                continue;
            end
            pop_en = ($urandom_range(0, 1) != 0);
            flush  = ($urandom_range(0, 49) == 0);
            ack    = can_ack() && ($urandom_range(0, 3) != 0);
            if (mout > 0 && $urandom_range(0, 2) != 0)
                drive_wr($urandom_range(0, 2), rand_pc(), rand_pc(),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                idle_wr();
            cycle();
        end
        ack = 1'b0;
        flush = 1'b0;
        idle_wr();
        cycle();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aq_ifu_ibuf_queue.md
Name: aq_ifu_ibuf_queue

Overview:
Instruction buffer between IPack and IDU. Accepts up to two decoded-boundary instructions per cycle from IPack and presents one instruction per cycle to IDU under the pop enable. Generates ibuf_ctrl_inst_fetch, the fetch-request credit consumed by IFU control, so that every issued fetch has guaranteed landing space. Sits downstream of IPack and upstream of the IDU decode stage.

Parameters:
DEPTH, 8, number of instruction entries (power of 2, >=4)
PC_WIDTH, 39, width of instruction virtual address
FETCH_INSTS, 2, max instructions written per fetch group (space reserved per outstanding fetch)

Ports:
forever_cpuclk  input  1  core clock
cpurst_b  input  1  synchronous active-low reset
ctrl_ibuf_pop_en  input  1  IDU not stalled; pop head when valid
ctrl_ibuf_flush  input  1  IF cancel (frontend flush or change of flow)
icache_ibuf_req_ack  input  1  fetch request accepted by ICache this cycle
ipack_ibuf_wr_vld  input  1  fetch group returning (may carry 0..2 insts)
ipack_ibuf_inst0_vld  input  1  instruction 0 valid
ipack_ibuf_inst0  input  32  instruction 0 (16-bit insts zero-extended)
ipack_ibuf_inst0_pc  input  PC_WIDTH  PC of instruction 0
ipack_ibuf_inst0_expt  input  1  fetch exception on instruction 0
ipack_ibuf_inst1_vld  input  1  instruction 1 valid (only with inst0_vld)
ipack_ibuf_inst1  input  32  instruction 1
ipack_ibuf_inst1_pc  input  PC_WIDTH  PC of instruction 1
ipack_ibuf_inst1_expt  input  1  fetch exception on instruction 1
ibuf_ctrl_inst_fetch  output  1  space available for another fetch group
ibuf_idu_inst_vld  output  1  head entry valid
ibuf_idu_inst  output  32  head instruction
ibuf_idu_pc  output  PC_WIDTH  head PC
ibuf_idu_expt  output  1  head exception flag
ibuf_top_empty  output  1  no entries and no outstanding fetches

Behaviour:
- Clock forever_cpuclk; reset cpurst_b synchronous active-low. Reset: count=0, rd/wr pointers=0, outstanding=0; ibuf_idu_inst_vld=0, ibuf_ctrl_inst_fetch=0, ibuf_top_empty=1; data regs don't care, output 0 when invalid.
- Storage: circular array of DEPTH entries {inst, pc, expt}; log2(DEPTH)-bit pointers wrap naturally; count is log2(DEPTH)+1 bits.
- Write: on ipack_ibuf_wr_vld, write inst0 at wr_ptr if inst0_vld, inst1 at wr_ptr+1 if inst1_vld; wr_ptr/count advance by number written (0,1,2). inst1_vld without inst0_vld is illegal (assertion).
- Read: head registered from array; data written in cycle N is visible at ibuf_idu_inst_vld in N+1 (no same-cycle bypass). Pop when ibuf_idu_inst_vld && ctrl_ibuf_pop_en; rd_ptr+1, count-1.
- Simultaneous push and pop: count += written - popped; reading an empty queue never pops.
- Outstanding fetches: 2-bit counter. +1 on ibuf_ctrl_inst_fetch && icache_ibuf_req_ack; -1 on ipack_ibuf_wr_vld; both same cycle -> unchanged. Saturates at 2; ack while at 2 is illegal (assertion).
- Credit: free = DEPTH - count - FETCH_INSTS*outstanding, computed from registered state. ibuf_ctrl_inst_fetch = (free >= FETCH_INSTS) && outstanding<2 && !flush_q, registered (one-cycle delay). Guarantees a write never overflows; write exceeding free space is an assertion failure.
- Flush: ctrl_ibuf_flush clears count, pointers, outstanding next cycle; ibuf_idu_inst_vld=0 next cycle. Writes and pops in the flush cycle are discarded. flush_q (flush delayed one cycle) suppresses ibuf_ctrl_inst_fetch for the cycle after flush so the change-of-flow PC is fetched cleanly.
- Flush and reset have priority over all other updates; reset mid-operation behaves as flush plus output clear.
- ibuf_top_empty = (count==0) && (outstanding==0).

Decomposition:
- Shared package aq_ifu_pkg: ibuf entry struct {inst[31:0], pc[PC_WIDTH-1:0], expt}, INST_WIDTH=32, FETCH_INSTS constant.
- One sub-module natural: aq_ifu_ibuf_credit (outstanding counter, free-space calc, fetch request register); entry array and pointers stay in top.

Test Plan:
- Reset, then no traffic -> cycle 1 after reset release ibuf_ctrl_inst_fetch=1, ibuf_idu_inst_vld=0, ibuf_top_empty=0 after first ack.
- Ack 1 fetch, write 2 insts (pc 0x1000,0x1004), pop_en=1 -> inst_vld next cycle with pc 0x1000, then 0x1004, then vld=0; outstanding returns to 0.
- pop_en=0, repeat fetch/write until DEPTH=8 filled -> ibuf_ctrl_inst_fetch drops when count+2*outstanding>6; never overflow; resumes after 2 pops.
- Same-cycle write of 1 inst and pop with count=3 -> count stays 3, rd/wr pointers wrap correctly past index 7.
- Flush with count=5, outstanding=1 and simultaneous wr_vld -> next cycle count=0, inst_vld=0, outstanding=0; ibuf_ctrl_inst_fetch=0 for one cycle, then 1.
- Write with inst1_vld=1, inst1_expt=1 -> second popped entry shows ibuf_idu_expt=1, first shows 0.
